// File: rtl/half_adder_sync_pkg.sv
// Shared defaults for the registered half-adder slice.
// Only default values live here; WIDTH and CNT_W are still per-instance
// module parameters on half_adder_sync.
package half_adder_sync_pkg;
   localparam int DEF_WIDTH = 1;   // operand bits, one half adder each
   localparam int DEF_CNT_W = 16;  // carry-event counter width
endpackage

// File: rtl/half_adder_bit.sv
// Single-bit half adder.
//   a, b  : operand bits
//   sum   : a ^ b
//   carry : a & b
// {carry,sum} is the 2-bit arithmetic sum of a and b. Plain operators are
// used so that X/Z on the inputs propagates with normal semantics.
module half_adder_bit (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

// File: rtl/half_adder_sync.sv
// WIDTH independent half adders with a combinational result, a one-cycle
// registered copy of that result, and a saturating count of captures that
// produced any carry.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (registers only)
//   a, b      : operands
//   in_valid  : capture a/b result this cycle
//   sum/carry : combinational a^b / a&b, independent of clk/rst/in_valid
//   sum_q/carry_q : result registered on the last capture (held otherwise)
//   out_valid : one-cycle pulse after each capture
//   carry_cnt : captures with non-zero carry, sticks at all-ones
module half_adder_sync
   import half_adder_sync_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // No carry chain: every bit position is its own half adder.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      half_adder_bit u_bit (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (sum[i]),
         .carry (carry[i])
      );
   end

   // Reset wins over a coincident capture; that capture is simply lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= '0;
         carry_q   <= '0;
         out_valid <= 1'b0;
         carry_cnt <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q   <= sum;
            carry_q <= carry;
            // Saturate rather than wrap so a full counter stays meaningful.
            if ((|carry) && (carry_cnt != CNT_MAX))
               carry_cnt <= carry_cnt + CNT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_half_adder_sync.sv
// Directed and randomised checks of half_adder_sync at three parameter
// points: WIDTH=1/CNT_W=16, WIDTH=4/CNT_W=16 and WIDTH=1/CNT_W=2.
module tb_half_adder_sync;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // WIDTH=1, CNT_W=16
   logic [0:0]  a1 = '0, b1 = '0, s1, c1, sq1, cq1;
   logic        iv1 = 1'b0, ov1;
   logic [15:0] cnt1;
   // WIDTH=4, CNT_W=16
   logic [3:0]  a4 = '0, b4 = '0, s4, c4, sq4, cq4;
   logic        iv4 = 1'b0, ov4;
   logic [15:0] cnt4;
   // WIDTH=1, CNT_W=2
   logic [0:0]  ac = '0, bc = '0, sc, cc, sqc, cqc;
   logic        ivc = 1'b0, ovc;
   logic [1:0]  cntc;

   half_adder_sync #(.WIDTH(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
      .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1),
      .out_valid(ov1), .carry_cnt(cnt1));

   half_adder_sync #(.WIDTH(4), .CNT_W(16)) u4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4),
      .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4),
      .out_valid(ov4), .carry_cnt(cnt4));

   half_adder_sync #(.WIDTH(1), .CNT_W(2)) uc (
      .clk(clk), .rst(rst), .a(ac), .b(bc), .in_valid(ivc),
      .sum(sc), .carry(cc), .sum_q(sqc), .carry_q(cqc),
      .out_valid(ovc), .carry_cnt(cntc));

   // Inputs change on the falling edge; registered outputs are sampled
   // 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; iv1 = 0; iv4 = 0; ivc = 0;
      tick();
      tick();
      total++;
      if ({sq1, cq1, ov1, cnt1} !== 19'd0)
         $display("FAIL reset_u1 got sq=%b cq=%b ov=%b cnt=%0d want all 0", sq1, cq1, ov1, cnt1);
      else pass_cnt++;
      total++;
      if ({sq4, cq4, ov4, cnt4} !== 25'd0)
         $display("FAIL reset_u4 got sq=%b cq=%b ov=%b cnt=%0d want all 0", sq4, cq4, ov4, cnt4);
      else pass_cnt++;
      total++;
      if ({sqc, cqc, ovc, cntc} !== 5'd0)
         $display("FAIL reset_uc got sq=%b cq=%b ov=%b cnt=%0d want all 0", sqc, cqc, ovc, cntc);
      else pass_cnt++;
   endtask

   // Truth table while still in reset: combinational path ignores rst.
   task automatic test_truth_table();
      logic [1:0] vin  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [1:0] vexp [4] = '{2'b00, 2'b01, 2'b01, 2'b10}; // {carry,sum}
      for (int i = 0; i < 4; i++) begin
         a1 = vin[i][1];
         b1 = vin[i][0];
         #10;
         total++;
         if ({c1, s1} !== vexp[i])
            $display("FAIL truth_%b got carry/sum=%b want %b", vin[i], {c1, s1}, vexp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_capture();
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0; a1 = 1; b1 = 1; iv1 = 1;
      tick();
      total++;
      if ({sq1, cq1, ov1, cnt1} !== {1'b0, 1'b1, 1'b1, 16'd1})
         $display("FAIL capture11 got sq=%b cq=%b ov=%b cnt=%0d want 0 1 1 1", sq1, cq1, ov1, cnt1);
      else pass_cnt++;
      // Idle cycle with different inputs: registers hold, valid drops.
      @(negedge clk);
      iv1 = 0; a1 = 1; b1 = 0;
      tick();
      total++;
      if ({sq1, cq1, ov1, cnt1} !== {1'b0, 1'b1, 1'b0, 16'd1})
         $display("FAIL hold got sq=%b cq=%b ov=%b cnt=%0d want 0 1 0 1", sq1, cq1, ov1, cnt1);
      else pass_cnt++;
      // Capture without carry: counter must not move.
      @(negedge clk);
      iv1 = 1;
      tick();
      total++;
      if ({sq1, cq1, ov1, cnt1} !== {1'b1, 1'b0, 1'b1, 16'd1})
         $display("FAIL nocarry got sq=%b cq=%b ov=%b cnt=%0d want 1 0 1 1", sq1, cq1, ov1, cnt1);
      else pass_cnt++;
      @(negedge clk);
      iv1 = 0;
   endtask

   task automatic test_width4();
      @(negedge clk);
      a4 = 4'b1010; b4 = 4'b0110; iv4 = 1;
      #1;
      total++;
      if ({s4, c4} !== {4'b1100, 4'b0010})
         $display("FAIL w4_comb got sum=%b carry=%b want 1100 0010", s4, c4);
      else pass_cnt++;
      tick();
      total++;
      if ({sq4, cq4, ov4, cnt4} !== {4'b1100, 4'b0010, 1'b1, 16'd1})
         $display("FAIL w4_reg got sq=%b cq=%b ov=%b cnt=%0d want 1100 0010 1 1", sq4, cq4, ov4, cnt4);
      else pass_cnt++;
      @(negedge clk);
      iv4 = 0;
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      @(negedge clk);
      ac = 1; bc = 1; ivc = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({ovc, cntc} !== {1'b1, exp_cnt[i]})
            $display("FAIL sat_%0d got ov=%b cnt=%0d want ov=1 cnt=%0d", i, ovc, cntc, exp_cnt[i]);
         else pass_cnt++;
      end
      @(negedge clk);
      ivc = 0;
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      rst = 1; iv1 = 1; a1 = 1; b1 = 1;
      #1;
      total++;
      if ({c1, s1} !== 2'b10)
         $display("FAIL rstprio_comb got carry/sum=%b want 10", {c1, s1});
      else pass_cnt++;
      tick();
      total++;
      if ({sq1, cq1, ov1, cnt1} !== 19'd0)
         $display("FAIL rstprio_reg got sq=%b cq=%b ov=%b cnt=%0d want all 0", sq1, cq1, ov1, cnt1);
      else pass_cnt++;
      // First capture right after release.
      @(negedge clk);
      rst = 0; a1 = 1; b1 = 0; iv1 = 1;
      tick();
      total++;
      if ({sq1, cq1, ov1, cnt1} !== {1'b1, 1'b0, 1'b1, 16'd0})
         $display("FAIL post_reset got sq=%b cq=%b ov=%b cnt=%0d want 1 0 1 0", sq1, cq1, ov1, cnt1);
      else pass_cnt++;
      @(negedge clk);
      iv1 = 0;
   endtask

   task automatic test_random();
      logic [3:0]  m_sq, m_cq, ra, rb;
      logic        m_ov, riv;
      logic [15:0] m_cnt;
      int          errs;
      @(negedge clk);
      rst = 1; iv4 = 0;
      tick();
      m_sq = '0; m_cq = '0; m_ov = 0; m_cnt = '0; errs = 0;
      @(negedge clk);
      rst = 0;
      for (int n = 0; n < 1000; n++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         riv = 1'($urandom_range(0, 1));
         a4 = ra; b4 = rb; iv4 = riv;
         #1;
         total++;
         if ({s4, c4} !== {ra ^ rb, ra & rb}) begin
            if (errs < 10)
               $display("FAIL rand_comb_%0d a=%b b=%b got sum=%b carry=%b want %b %b",
                        n, ra, rb, s4, c4, ra ^ rb, ra & rb);
            errs++;
         end else pass_cnt++;
         if (riv) begin
            m_sq = ra ^ rb;
            m_cq = ra & rb;
            if ((ra & rb) != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
         m_ov = riv;
         tick();
         total++;
         if ({sq4, cq4, ov4, cnt4} !== {m_sq, m_cq, m_ov, m_cnt}) begin
            if (errs < 10)
               $display("FAIL rand_reg_%0d got sq=%b cq=%b ov=%b cnt=%0d want %b %b %b %0d",
                        n, sq4, cq4, ov4, cnt4, m_sq, m_cq, m_ov, m_cnt);
            errs++;
         end else pass_cnt++;
         @(negedge clk);
      end
      iv4 = 0;
   endtask

   initial begin
      test_reset();
      test_truth_table();
      test_capture();
      test_width4();
      test_saturate();
      test_reset_priority();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/half_adder_sync.md
HALF_ADDER_SYNC -- requirements
Module: half_adder_sync

Interface
REQ-001 Parameter WIDTH, default 1: bit-width of each operand; each bit position is an independent half adder.
REQ-002 Parameter CNT_W, default 16: width of the carry-event counter.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port a  input  WIDTH: operand A.
REQ-006 Port b  input  WIDTH: operand B.
REQ-007 Port in_valid  input  1: a/b are to be captured into the registered path this cycle.
REQ-008 Port sum  output  WIDTH: combinational per-bit sum, a XOR b.
REQ-009 Port carry  output  WIDTH: combinational per-bit carry, a AND b.
REQ-010 Port sum_q  output  WIDTH: registered sum.
REQ-011 Port carry_q  output  WIDTH: registered carry.
REQ-012 Port out_valid  output  1: sum_q/carry_q hold a freshly captured result.
REQ-013 Port carry_cnt  output  CNT_W: count of captured results with any carry bit set.

Function
REQ-014 sum SHALL equal a XOR b bitwise and carry SHALL equal a AND b bitwise, with zero latency and no dependence on clk, rst or in_valid.
REQ-015 Truth table per bit SHALL be: 00->sum0 carry0; 01->sum1 carry0; 10->sum1 carry0; 11->sum0 carry1.
REQ-016 Per bit, {carry,sum} SHALL equal the 2-bit arithmetic sum of a and b, with no carry propagation between bit positions.
REQ-017 On a rising edge with in_valid=1 and rst=0, sum_q/carry_q SHALL load a XOR b / a AND b, and out_valid SHALL be 1 in the next cycle (latency 1).
REQ-018 On a rising edge with in_valid=0 and rst=0, sum_q/carry_q SHALL hold their value and out_valid SHALL be 0.
REQ-019 carry_cnt SHALL increment by 1 on each capture where (a AND b) is non-zero.
REQ-020 carry_cnt SHALL saturate at 2^CNT_W-1; it SHALL NOT wrap.
REQ-021 There is no backpressure; every in_valid cycle SHALL be captured, and back-to-back captures SHALL produce back-to-back out_valid pulses.
REQ-022 X or Z on a/b SHALL NOT be masked; outputs SHALL follow standard operator semantics.

Reset
REQ-023 When rst=1 at a rising edge, sum_q, carry_q, out_valid and carry_cnt SHALL all be 0 after that edge.
REQ-024 Reset SHALL take priority over a simultaneous in_valid; that capture is dropped.
REQ-025 Reset SHALL NOT affect the combinational sum/carry outputs.
REQ-026 After rst deasserts, the first in_valid SHALL capture normally with no extra dead cycles.

Structure
REQ-027 The block needs no shared package types; WIDTH and CNT_W SHALL be module parameters only.
REQ-028 The design SHALL contain one sub-module, half_adder_bit (1-bit a,b -> sum,carry), instantiated WIDTH times via a generate loop; the registers and counter SHALL live in half_adder_sync.

Verification
REQ-029 WIDTH=1: apply a,b = 00, 01, 10, 11, holding each 10 ns -> sum/carry = 0/0, 1/0, 1/0, 0/1 with no clock required.
REQ-030 WIDTH=1: rst for 2 cycles, then in_valid with a=1,b=1 -> one cycle later sum_q=0, carry_q=1, out_valid=1, carry_cnt=1.
REQ-031 WIDTH=4: in_valid with a=4'b1010, b=4'b0110 -> sum=4'b1100 and carry=4'b0010 immediately; sum_q/carry_q take the same values one cycle later.
REQ-032 CNT_W=2: capture 5 consecutive a=1,b=1 values -> carry_cnt = 1, 2, 3, 3, 3.
REQ-033 Assert rst and in_valid on the same edge with a=1,b=1 -> sum_q=0, carry_q=0, out_valid=0, carry_cnt=0; combinational carry=1.
REQ-034 Random a/b/in_valid for 1000 cycles -> every output matches a reference model each cycle.
